// File: rtl/phase_search_ctrl_pkg.sv
// Shared state encoding and default tuning for the sampling-phase search controller.
package phase_search_ctrl_pkg;

   localparam int DEF_NPHASE     = 4;
   localparam int DEF_WIN_LEN    = 511;
   localparam int DEF_SETTLE_LEN = 16;
   localparam int DEF_NB_ERR     = 16;
   localparam int DEF_LOCK_THR   = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_EVAL,
      ST_LOCK
   } state_t;

endpackage

// File: rtl/phase_search_ctrl_err_window_acc.sv
// Baud-strobe counter with saturating error accumulator; o_done fires combinationally on the last strobe
// of a settle or measurement window, and both counter and accumulator restart on that strobe.
module err_window_acc
   import phase_search_ctrl_pkg::*;
#(
   parameter int WIN_LEN    = DEF_WIN_LEN,
   parameter int SETTLE_LEN = DEF_SETTLE_LEN,
   parameter int NB_ERR     = DEF_NB_ERR
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_run,
   input  logic              i_settle,
   input  logic              i_valid,
   input  logic              i_err,
   output logic [NB_ERR-1:0] o_acc_next,
   output logic              o_done
);

   localparam int MAXLEN = (WIN_LEN > SETTLE_LEN) ? WIN_LEN : SETTLE_LEN;
   localparam int CW     = $clog2(MAXLEN + 1);

   logic [CW-1:0]     r_cnt;
   logic [NB_ERR-1:0] r_acc;
   logic [CW-1:0]     w_last_idx;
   logic              w_strobe;

   assign w_strobe   = i_run & i_valid;
   assign w_last_idx = i_settle ? CW'(SETTLE_LEN - 1) : CW'(WIN_LEN - 1);
   assign o_done     = w_strobe && (r_cnt == w_last_idx);

   // Settle strobes only advance the counter; errors there are not part of any window.
   assign o_acc_next = (w_strobe && !i_settle && i_err && (r_acc != '1)) ? r_acc + 1'b1 : r_acc;

   always_ff @(posedge clock) begin
      if (!i_reset || i_clear || o_done) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (w_strobe) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= o_acc_next;
      end
   end

endmodule

// File: rtl/phase_search_ctrl.sv
// Sweeps the slicer sampling phase, measures BER per phase over fixed windows and locks on the best one,
// re-searching when a locked window exceeds the error threshold.
module phase_search_ctrl
   import phase_search_ctrl_pkg::*;
#(
   parameter int NPHASE     = DEF_NPHASE,
   parameter int WIN_LEN    = DEF_WIN_LEN,
   parameter int SETTLE_LEN = DEF_SETTLE_LEN,
   parameter int NB_ERR     = DEF_NB_ERR,
   parameter int LOCK_THR   = DEF_LOCK_THR
) (
   input  logic                      clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_valid,
   input  logic                      i_err,
   output logic [$clog2(NPHASE)-1:0] o_phase,
   output logic                      o_ber_enable,
   output logic                      o_ber_clear,
   output logic                      o_locked,
   output logic [NB_ERR-1:0]         o_best_err
);

   localparam int PW = $clog2(NPHASE);

   state_t            r_state;
   logic [PW-1:0]     r_phase;
   logic [PW-1:0]     r_best_phase;
   logic [NB_ERR-1:0] r_best;
   logic [NB_ERR-1:0] r_win_err;
   logic              r_ber_enable;
   logic              r_ber_clear;
   logic              r_locked;

   logic [NB_ERR-1:0] w_acc_next;
   logic              w_done;
   logic              w_new_best;
   logic [PW-1:0]     w_eval_phase;

   err_window_acc #(
      .WIN_LEN    (WIN_LEN),
      .SETTLE_LEN (SETTLE_LEN),
      .NB_ERR     (NB_ERR)
   ) u_acc (
      .clock      (clock),
      .i_reset    (i_reset),
      .i_clear    ((r_state == ST_IDLE) || (r_state == ST_EVAL)),
      .i_run      ((r_state == ST_SETTLE) || (r_state == ST_MEASURE) || (r_state == ST_LOCK)),
      .i_settle   (r_state == ST_SETTLE),
      .i_valid    (i_valid),
      .i_err      (i_err),
      .o_acc_next (w_acc_next),
      .o_done     (w_done)
   );

   // Strict less-than keeps the lowest phase index on ties.
   assign w_new_best   = (r_win_err < r_best);
   assign w_eval_phase = w_new_best ? r_phase : r_best_phase;

   always_ff @(posedge clock) begin
      if (!i_reset) begin
         r_state      <= ST_IDLE;
         r_phase      <= '0;
         r_best_phase <= '0;
         r_best       <= '1;
         r_win_err    <= '0;
         r_ber_enable <= 1'b0;
         r_ber_clear  <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         r_ber_clear <= 1'b0;
         if (!i_enable) begin
            r_state      <= ST_IDLE;
            r_locked     <= 1'b0;
            r_ber_enable <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state      <= ST_SETTLE;
                  r_phase      <= '0;
                  r_best_phase <= '0;
                  r_best       <= '1;
               end
               ST_SETTLE: begin
                  if (w_done) begin
                     r_state      <= ST_MEASURE;
                     r_ber_enable <= 1'b1;
                     r_ber_clear  <= 1'b1;
                  end
               end
               ST_MEASURE: begin
                  if (w_done) begin
                     r_state      <= ST_EVAL;
                     r_win_err    <= w_acc_next;
                     r_ber_enable <= 1'b0;
                  end
               end
               ST_EVAL: begin
                  if (w_new_best) begin
                     r_best       <= r_win_err;
                     r_best_phase <= r_phase;
                  end
                  if (r_phase == PW'(NPHASE - 1)) begin
                     r_state      <= ST_LOCK;
                     r_phase      <= w_eval_phase;
                     r_locked     <= 1'b1;
                     r_ber_enable <= 1'b1;
                     r_ber_clear  <= 1'b1;
                  end else begin
                     r_state <= ST_SETTLE;
                     r_phase <= r_phase + 1'b1;
                  end
               end
               ST_LOCK: begin
                  if (w_done) begin
                     if (w_acc_next > NB_ERR'(LOCK_THR)) begin
                        r_state      <= ST_SETTLE;
                        r_locked     <= 1'b0;
                        r_ber_enable <= 1'b0;
                        r_phase      <= '0;
                        r_best_phase <= '0;
                        r_best       <= '1;
                     end else begin
                        r_ber_clear <= 1'b1;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_phase      = r_phase;
   assign o_ber_enable = r_ber_enable;
   assign o_ber_clear  = r_ber_clear;
   assign o_locked     = r_locked;
   assign o_best_err   = r_best;

endmodule

// File: doc/phase_search_ctrl.md
PHASE_SEARCH_CTRL -- requirements
Module: phase_search_ctrl

Interface
REQ-001 Parameter NPHASE, default 4: number of selectable sampling phases.
REQ-002 Parameter WIN_LEN, default 511: baud strobes per measurement window.
REQ-003 Parameter SETTLE_LEN, default 16: baud strobes discarded after every phase change.
REQ-004 Parameter NB_ERR, default 16: width of the error accumulator.
REQ-005 Parameter LOCK_THR, default 8: maximum errors per window tolerated while locked.
REQ-006 clock  in  1  system clock; all logic on rising edge.
REQ-007 i_reset  in  1  synchronous, active-low reset.
REQ-008 i_enable  in  1  run search; low forces IDLE.
REQ-009 i_valid  in  1  one-cycle baud strobe, shared with PRBS/FIR.
REQ-010 i_err  in  1  slicer-vs-PRBS mismatch; qualified by i_valid.
REQ-011 o_phase  out  clog2(NPHASE)  phase selector to the slicer.
REQ-012 o_ber_enable  out  1  enable for the external BER counters.
REQ-013 o_ber_clear  out  1  one-cycle clear pulse for the external BER counters.
REQ-014 o_locked  out  1  high only in LOCK.
REQ-015 o_best_err  out  NB_ERR  lowest window error count found in the current search.

Function
REQ-016 FSM states: IDLE, SETTLE, MEASURE, EVAL, LOCK.
REQ-017 IDLE: on i_enable=1, go to SETTLE next cycle with o_phase=0 and best=all-ones.
REQ-018 SETTLE: count i_valid strobes; after the SETTLE_LEN-th strobe, go to MEASURE next cycle.
REQ-019 Entry to MEASURE: assert o_ber_clear for exactly one cycle and zero the error accumulator.
REQ-020 MEASURE: each i_valid adds i_err to the accumulator, which saturates at 2^NB_ERR-1; after the WIN_LEN-th strobe, go to EVAL next cycle.
REQ-021 The i_err accompanying the final (WIN_LEN-th) strobe is included in the window count.
REQ-022 EVAL (one cycle): if acc < best, then best<=acc and best_phase<=o_phase; strict less-than, so ties keep the lower phase index.
REQ-023 EVAL: if o_phase<NPHASE-1, increment o_phase and go to SETTLE; otherwise set o_phase<=best_phase and go to LOCK.
REQ-024 LOCK: run repeated WIN_LEN windows, with the accumulator cleared and o_ber_clear pulsed at each window start; no settle period.
REQ-025 LOCK: at window end, if acc>LOCK_THR, restart the search (o_locked=0, o_phase=0, best=all-ones, SETTLE); acc=LOCK_THR stays locked.
REQ-026 o_ber_enable is 1 in MEASURE and LOCK, and 0 otherwise.
REQ-027 i_enable=0 in any state: go to IDLE next cycle; o_locked=0, o_ber_enable=0; o_phase holds its value.
REQ-028 Strobes arriving during EVAL are ignored.
REQ-029 i_valid with no accompanying i_err pulse contributes 0.

Reset
REQ-030 When i_reset=0 at a clock edge: state=IDLE, o_phase=0, o_ber_enable=0, o_ber_clear=0, o_locked=0, o_best_err=all-ones, all counters=0.
REQ-031 Reset has priority over i_enable and i_valid, and takes effect mid-window with no residual state.

Structure
REQ-032 The shared package holds the state enumeration and the default values of NPHASE, WIN_LEN, SETTLE_LEN, NB_ERR and LOCK_THR.
REQ-033 One sub-module, err_window_acc, holds the strobe counter, the saturating error accumulator and the done pulse; the FSM lives in phase_search_ctrl.

Verification
REQ-034 Reset scenario: hold i_reset=0 for 3 cycles with i_enable=1 -> all REQ-030 reset values; after release, SETTLE is entered 1 cycle later.
REQ-035 Single good phase: i_err=1 on every strobe for phases 0, 1 and 3, and 0 for phase 2 -> o_locked=1 with o_phase=2 and o_best_err=0 after 4*(16+511) strobes plus EVAL cycles.
REQ-036 Tie: phases 1 and 3 give 5 errors each, phases 0 and 2 give 100 each -> lock on o_phase=1 with o_best_err=5.
REQ-037 Locked threshold: inject 8 errors in one locked window -> stays locked; inject 9 in the next -> o_locked=0, o_phase=0, SETTLE.
REQ-038 Abort: drop i_enable mid-MEASURE -> IDLE next cycle with o_ber_enable=0; raise i_enable again -> fresh search from phase 0.
REQ-039 Saturation: NB_ERR=4, WIN_LEN=31, all strobes in error -> window count 15, no wrap.
